// File: rtl/demux_1to8_sched.sv
// Round-robin scheduler steering one upstream word stream to eight downstream channels.
// Optional SEND timeout with drop counting is enabled by defining DEMUX_TIMEOUT_EN.
module demux_1to8_sched #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    en_mask,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [7:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [7:0]    out_ready,
    output logic [2:0]    sel,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    // Handshake rule: a word moves on a rising edge only when valid and ready are
    // both high in the cycle before it; valid never waits on ready, and once a
    // channel sees out_valid the word and sel stay stable until out_ready[sel].
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state;
    state_t     state_n;
    logic       armed;
    logic [2:0] ptr;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    logic       accept;
    logic       done;
    logic       leave;

    // First enabled channel at or after ptr, wrapping modulo 8.
    always_comb begin
        pick  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && en_mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // armed keeps in_ready low until the first edge after reset is released.
    assign in_ready = armed && (state == IDLE) && (|en_mask);
    assign accept   = in_valid && in_ready;
    assign done     = (state == SEND) && out_ready[sel];
    assign busy     = (state == SEND);

    always_comb begin
        out_valid = '0;
        if (state == SEND) out_valid[sel] = 1'b1;
    end

`ifdef DEMUX_TIMEOUT_EN
    localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [WCW-1:0] wait_cnt;
    logic [7:0]     drops;
    logic           expire;

    assign expire   = (state == SEND) && !out_ready[sel] && (wait_cnt == WCW'(TIMEOUT));
    assign leave    = done || expire;
    assign drop_cnt = drops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            drops    <= '0;
        end else begin
            if (accept) wait_cnt <= '0;
            else if ((state == SEND) && !leave) wait_cnt <= wait_cnt + 1'b1;
            if (expire && (drops != 8'hFF)) drops <= drops + 8'd1;
        end
    end
`else
    assign leave    = done;
    assign drop_cnt = 8'd0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SEND;
            SEND:    if (leave)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            ptr      <= '0;
            sel      <= '0;
            out_data <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                out_data <= in_data;
                sel      <= pick;
            end
            if (leave) ptr <= sel + 3'd1;
        end
    end

endmodule

// File: tb/tb_demux_1to8_sched.sv
// Directed bench for demux_1to8_sched; timeout scenarios build when DEMUX_TIMEOUT_EN is defined.
module tb_demux_1to8_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] en_mask;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] out_valid;
    logic [7:0] out_data;
    logic [7:0] out_ready;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] drop_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    demux_1to8_sched #(.DW(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        step();
    endtask

    // Waits (bounded) for in_ready, then presents one word for exactly one edge.
    task automatic push_word(input logic [7:0] d);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check_cnt++;
        if (!in_ready) begin
            $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end else begin
            pass_cnt++;
            in_valid = 1'b1;
            in_data  = d;
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en_mask   = 8'hFF;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 8'hFF;
        #2;
        check_cnt++;
        if ({out_valid, sel, busy, in_ready, out_data, drop_cnt} !== 29'd0)
            $display("FAIL reset_state: out_valid=%h sel=%0d busy=%0b in_ready=%0b out_data=%h drop_cnt=%0d, required all 0",
                     out_valid, sel, busy, in_ready, out_data, drop_cnt);
        else pass_cnt++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_cnt++;
        if (in_ready !== 1'b0) $display("FAIL ready_before_edge: in_ready=%0b required 0", in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_edge: in_ready=%0b required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_v;
        do_reset();
        en_mask   = 8'hFF;
        out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            push_word(8'h10 + 8'(i));
            exp_v = 8'h01 << i;
            check_cnt++;
            if (out_valid !== exp_v || sel !== 3'(i) || out_data !== 8'h10 + 8'(i) || busy !== 1'b1)
                $display("FAIL rr_word%0d: out_valid=%h sel=%0d data=%h busy=%0b, required %h %0d %h 1",
                         i, out_valid, sel, out_data, busy, exp_v, i, 8'h10 + 8'(i));
            else pass_cnt++;
            step();
            check_cnt++;
            if (out_valid !== 8'h00 || busy !== 1'b0)
                $display("FAIL rr_release%0d: out_valid=%h busy=%0b, required 00 0", i, out_valid, busy);
            else pass_cnt++;
        end
        push_word(8'h18);
        check_cnt++;
        if (out_valid !== 8'h01 || sel !== 3'd0 || out_data !== 8'h18)
            $display("FAIL rr_wrap: out_valid=%h sel=%0d data=%h, required 01 0 18", out_valid, sel, out_data);
        else pass_cnt++;
        step();
    endtask

    task automatic test_sparse_mask();
        logic [2:0] exp_s[3] = '{3'd2, 3'd5, 3'd2};
        logic [7:0] exp_v[3] = '{8'h04, 8'h20, 8'h04};
        do_reset();
        en_mask   = 8'h24;
        out_ready = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            push_word(8'hC0 + 8'(i));
            check_cnt++;
            if (sel !== exp_s[i] || out_valid !== exp_v[i] || out_data !== 8'hC0 + 8'(i))
                $display("FAIL sparse%0d: sel=%0d out_valid=%h data=%h, required %0d %h %h",
                         i, sel, out_valid, out_data, exp_s[i], exp_v[i], 8'hC0 + 8'(i));
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_empty_mask();
        int bad = 0;
        do_reset();
        en_mask   = 8'h00;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        repeat (10) begin
            step();
            if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL empty_mask: %0d cycles with in_ready/busy high, required 0", bad);
        else pass_cnt++;
        en_mask = 8'h01;
        step();
        in_valid = 1'b0;
        check_cnt++;
        if (out_valid !== 8'h01 || out_data !== 8'hA5 || busy !== 1'b1)
            $display("FAIL mask_enable: out_valid=%h data=%h busy=%0b, required 01 a5 1", out_valid, out_data, busy);
        else pass_cnt++;
        step();
    endtask

    task automatic test_hold();
        int bad = 0;
        do_reset();
        en_mask   = 8'h08;
        out_ready = 8'hF7;
        push_word(8'h44);
        check_cnt++;
        if (out_valid !== 8'h08 || sel !== 3'd3)
            $display("FAIL hold_start: out_valid=%h sel=%0d, required 08 3", out_valid, sel);
        else pass_cnt++;
        en_mask = 8'h00;
        repeat (5) begin
            step();
            if (out_valid !== 8'h08 || out_data !== 8'h44 || busy !== 1'b1) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        else pass_cnt++;
        out_ready = 8'hFF;
        step();
        check_cnt++;
        if (out_valid !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL hold_release: out_valid=%h busy=%0b in_ready=%0b, required 00 0 0", out_valid, busy, in_ready);
        else pass_cnt++;
        en_mask = 8'hFF;
        push_word(8'h45);
        check_cnt++;
        if (sel !== 3'd4) $display("FAIL hold_next_ptr: sel=%0d required 4", sel);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        en_mask   = 8'hFF;
        out_ready = 8'hFF;
        push_word(8'h01);
        step();
        out_ready = 8'h00;
        push_word(8'h02);
        check_cnt++;
        if (sel !== 3'd1 || busy !== 1'b1) $display("FAIL midrst_setup: sel=%0d busy=%0b, required 1 1", sel, busy);
        else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        check_cnt++;
        if (out_valid !== 8'h00 || busy !== 1'b0 || sel !== 3'd0 || in_ready !== 1'b0)
            $display("FAIL midrst_async: out_valid=%h busy=%0b sel=%0d in_ready=%0b, required 00 0 0 0",
                     out_valid, busy, sel, in_ready);
        else pass_cnt++;
        en_mask = 8'h30;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_cnt++;
        if (in_ready !== 1'b0) $display("FAIL midrst_ready: in_ready=%0b required 0", in_ready);
        else pass_cnt++;
        push_word(8'h77);
        check_cnt++;
        if (sel !== 3'd4 || out_valid !== 8'h10 || out_data !== 8'h77)
            $display("FAIL midrst_first: sel=%0d out_valid=%h data=%h, required 4 10 77", sel, out_valid, out_data);
        else pass_cnt++;
        out_ready = 8'hFF;
        step();
    endtask

`ifdef DEMUX_TIMEOUT_EN
    task automatic test_timeout();
        int cycles = 0;
        int n;
        do_reset();
        en_mask   = 8'hFF;
        out_ready = 8'hFD;
        push_word(8'h20);
        step();
        push_word(8'h21);
        while (busy && cycles < 100) begin
            cycles++;
            step();
        end
        check_cnt++;
        if (cycles != 16) $display("FAIL timeout_cycles: SEND lasted %0d cycles, required 16", cycles);
        else pass_cnt++;
        check_cnt++;
        if (drop_cnt !== 8'd1) $display("FAIL timeout_drop: drop_cnt=%0d required 1", drop_cnt);
        else pass_cnt++;
        push_word(8'h22);
        check_cnt++;
        if (sel !== 3'd2) $display("FAIL timeout_next: sel=%0d required 2", sel);
        else pass_cnt++;
        step();
        out_ready = 8'h00;
        push_word(8'h23);
        repeat (15) step();
        out_ready = 8'h08;
        step();
        check_cnt++;
        if (busy !== 1'b0 || drop_cnt !== 8'd1)
            $display("FAIL ready_wins: busy=%0b drop_cnt=%0d, required 0 1", busy, drop_cnt);
        else pass_cnt++;
        out_ready = 8'h00;
        for (int i = 0; i < 300; i++) begin
            push_word(8'(i));
            n = 0;
            while (busy && n < 40) begin
                step();
                n++;
            end
        end
        check_cnt++;
        if (drop_cnt !== 8'd255) $display("FAIL drop_saturate: drop_cnt=%0d required 255", drop_cnt);
        else pass_cnt++;
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        do_reset();
        en_mask   = 8'hFF;
        out_ready = 8'h00;
        push_word(8'h5A);
        repeat (40) begin
            step();
            if (out_valid !== 8'h01 || busy !== 1'b1) bad++;
        end
        check_cnt++;
        if (bad != 0 || drop_cnt !== 8'd0)
            $display("FAIL no_timeout: %0d cycles left SEND, drop_cnt=%0d, required 0 0", bad, drop_cnt);
        else pass_cnt++;
        out_ready = 8'h01;
        step();
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL no_timeout_release: busy=%0b required 0", busy);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_sparse_mask();
        test_empty_mask();
        test_hold();
        test_reset_mid_send();
`ifdef DEMUX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
